// File: rtl/sum_array_run_ctrl_if.sv
// rtl/sum_array_run_ctrl_if.sv - command, load stream, kernel and memory port bundle for the run controller
interface sum_array_run_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_n;
  logic              busy;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              k_start;
  logic              k_finish;
  logic [ADDR_W-1:0] k_n;
  logic [DATA_W-1:0] k_res;
  logic              k_read_en;
  logic [ADDR_W-1:0] k_read_addr;
  logic              k_write_en;
  logic [ADDR_W-1:0] k_write_addr;
  logic [DATA_W-1:0] k_write_val;
  logic              mem_read_en;
  logic [ADDR_W-1:0] mem_read_addr;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_val;

  // Host and kernel side: drives commands, load words and kernel activity.
  modport master (
    output cmd_start, cmd_n, load_valid, load_data, k_finish, k_res,
           k_read_en, k_read_addr, k_write_en, k_write_addr, k_write_val,
    input  busy, load_ready, done, result, k_start, k_n,
           mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_val
  );

  // Controller side.
  modport slave (
    input  cmd_start, cmd_n, load_valid, load_data, k_finish, k_res,
           k_read_en, k_read_addr, k_write_en, k_write_addr, k_write_val,
    output busy, load_ready, done, result, k_start, k_n,
           mem_read_en, mem_read_addr, mem_write_en, mem_write_addr, mem_write_val
  );
endinterface

// File: rtl/sum_array_run_ctrl.sv
// rtl/sum_array_run_ctrl.sv - loads n words into array memory, runs the sum kernel, captures its result
module sum_array_run_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sum_array_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    KSTART = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] result_q;
  logic              done_q;

  logic accept;
  logic load_hs;
  logic finish_hs;

  assign accept    = (state == IDLE) && bus.cmd_start;
  assign load_hs   = (state == LOAD) && bus.load_valid;
  assign finish_hs = (state == RUN) && bus.k_finish;

  assign bus.k_n    = n_q;
  assign bus.result = result_q;
  assign bus.done   = done_q;

  // State register; reset aborts any load or run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus status and memory-port ownership; only the current owner reaches mem_*.
  always_comb begin
    state_nxt          = state;
    bus.busy           = 1'b0;
    bus.load_ready     = 1'b0;
    bus.k_start        = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.mem_read_addr  = '0;
    bus.mem_write_en   = 1'b0;
    bus.mem_write_addr = '0;
    bus.mem_write_val  = '0;
    case (state)
      IDLE: begin
        if (bus.cmd_start) begin
          state_nxt = (bus.cmd_n != '0) ? LOAD : KSTART;
        end
      end
      LOAD: begin
        bus.busy       = 1'b1;
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          bus.mem_write_en   = 1'b1;
          bus.mem_write_addr = cnt;
          bus.mem_write_val  = bus.load_data;
          if (cnt == n_q - ADDR_W'(1)) begin
            state_nxt = KSTART;
          end
        end
      end
      KSTART: begin
        bus.busy    = 1'b1;
        bus.k_start = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        bus.busy           = 1'b1;
        bus.mem_read_en    = bus.k_read_en;
        bus.mem_read_addr  = bus.k_read_addr;
        bus.mem_write_en   = bus.k_write_en;
        bus.mem_write_addr = bus.k_write_addr;
        bus.mem_write_val  = bus.k_write_val;
        if (bus.k_finish) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, load address counter, result capture and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish_hs;
      if (accept) begin
        n_q <= bus.cmd_n;
        cnt <= '0;
      end else if (load_hs) begin
        cnt <= cnt + ADDR_W'(1);
      end
      if (finish_hs) begin
        result_q <= bus.k_res;
      end
    end
  end

endmodule

// File: tb/tb_sum_array_run_ctrl.sv
// tb/tb_sum_array_run_ctrl.sv - randomized and directed bench for sum_array_run_ctrl
module tb_sum_array_run_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   knoise;

  sum_array_run_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  sum_array_run_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a job is either loading (words left), waiting to kick, or running.
  bit          m_busy;
  int          m_left;
  bit          m_kick;
  int          m_addr;
  logic [9:0]  m_n;
  logic [31:0] m_result;
  bit          m_done;

  always @(negedge clk) begin
    bit ld, ks, run;
    logic        e_we, e_re;
    logic [9:0]  e_wa, e_ra;
    logic [31:0] e_wv;
    if (!rst_n) begin
      m_busy = 0; m_left = 0; m_kick = 0; m_addr = 0;
      m_n = '0; m_result = '0; m_done = 0;
    end
    ld  = m_busy && (m_left > 0);
    ks  = m_busy && (m_left == 0) && m_kick;
    run = m_busy && (m_left == 0) && !m_kick;
    e_we = 0; e_wa = '0; e_wv = '0; e_re = 0; e_ra = '0;
    if (ld && bus.load_valid) begin
      e_we = 1; e_wa = 10'(m_addr); e_wv = bus.load_data;
    end else if (run) begin
      e_we = bus.k_write_en; e_wa = bus.k_write_addr; e_wv = bus.k_write_val;
      e_re = bus.k_read_en;  e_ra = bus.k_read_addr;
    end
    chk("busy", bus.busy, m_busy);
    chk("load_ready", bus.load_ready, ld);
    chk("k_start", bus.k_start, ks);
    chk("done", bus.done, m_done);
    chk("result", bus.result, m_result);
    chk("k_n", bus.k_n, m_n);
    chk("mem_write_en", bus.mem_write_en, e_we);
    chk("mem_write_addr", bus.mem_write_addr, e_wa);
    chk("mem_write_val", bus.mem_write_val, e_wv);
    chk("mem_read_en", bus.mem_read_en, e_re);
    chk("mem_read_addr", bus.mem_read_addr, e_ra);
    if (rst_n) begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.cmd_start) begin
          m_busy = 1; m_n = bus.cmd_n; m_left = int'(bus.cmd_n); m_addr = 0; m_kick = 1;
        end
      end else if (ld) begin
        if (bus.load_valid) begin
          m_left--; m_addr++;
        end
      end else if (ks) begin
        m_kick = 0;
      end else if (bus.k_finish) begin
        m_result = bus.k_res; m_done = 1; m_busy = 0;
      end
    end
  end

  // Observation log used by the directed literal checks.
  int          kst;
  int          dn;
  logic [9:0]  wr_addr[$];
  logic [31:0] wr_val[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.k_start) kst++;
      if (bus.done) dn++;
      if (bus.mem_write_en) begin
        wr_addr.push_back(bus.mem_write_addr);
        wr_val.push_back(bus.mem_write_val);
      end
    end
  end

  task automatic clear_log();
    kst = 0; dn = 0; wr_addr.delete(); wr_val.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (knoise) begin
      bus.k_read_en    = 1'($urandom);
      bus.k_read_addr  = 10'($urandom);
      bus.k_write_en   = 1'($urandom);
      bus.k_write_addr = 10'($urandom);
      bus.k_write_val  = $urandom;
    end
  endtask

  // mode: 0 valid held high, 1 valid toggling, 2 random valid.
  task automatic do_cmd(input int n, input int mode, input bit seq, input int fin_delay,
                        input bit noise, output logic [31:0] sum);
    int cnt;
    int g;
    bus.cmd_start = 1'b1;
    bus.cmd_n     = 10'(n);
    step();
    bus.cmd_start = 1'b0;
    cnt = 0; g = 0; sum = '0;
    while (cnt < n && g < 5000) begin
      bus.load_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((g % 2) == 0) : 1'($urandom);
      bus.load_data  = seq ? 32'(cnt + 1) : $urandom;
      if (noise) begin
        bus.cmd_start = 1'($urandom);
        bus.k_finish  = 1'($urandom);
      end
      if (bus.load_valid && bus.load_ready) begin
        cnt++;
        sum += bus.load_data;
      end
      step();
      g++;
    end
    bus.load_valid = 1'b0;
    bus.k_finish   = 1'b0;
    bus.cmd_start  = 1'b0;
    if (cnt < n) chk("load_timeout", 64'(cnt), 64'(n));
    chk("kstart_after_load", bus.k_start, 1'b1);
    chk("ready_dropped", bus.load_ready, 1'b0);
    step();
    for (int i = 0; i < fin_delay; i++) begin
      if (noise) bus.cmd_start = 1'($urandom);
      step();
    end
    bus.cmd_start = 1'b0;
    bus.k_finish  = 1'b1;
    bus.k_res     = sum;
    step();
    bus.k_finish  = 1'b0;
    bus.k_res     = $urandom;
    chk("done_pulse", bus.done, 1'b1);
    chk("result_sum", bus.result, sum);
    step();
    chk("done_single", bus.done, 1'b0);
  endtask

  initial begin
    logic [31:0] s;
    checks = 0; errors = 0; knoise = 0;
    rst_n = 1'b0;
    bus.cmd_start = 0; bus.cmd_n = '0; bus.load_valid = 0; bus.load_data = '0;
    bus.k_finish = 0; bus.k_res = '0; bus.k_read_en = 0; bus.k_read_addr = '0;
    bus.k_write_en = 0; bus.k_write_addr = '0; bus.k_write_val = '0;
    clear_log();
    repeat (2) step();
    chk("rst_result", bus.result, 32'd0);
    chk("rst_k_n", bus.k_n, 10'd0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    step();

    // 1: four words 1..4 back to back, kernel answers 10.
    clear_log();
    do_cmd(4, 0, 1, 0, 0, s);
    chk("t1_result", bus.result, 32'd10);
    chk("t1_writes", 64'(wr_addr.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      chk("t1_addr", wr_addr[i], 10'(i));
      chk("t1_val", wr_val[i], 32'(i + 1));
    end
    chk("t1_kstart", 64'(kst), 64'd1);
    chk("t1_done", 64'(dn), 64'd1);

    // 2: valid toggling, addresses stay contiguous.
    clear_log();
    do_cmd(4, 1, 1, 1, 0, s);
    chk("t2_writes", 64'(wr_addr.size()), 64'd4);
    for (int i = 0; i < wr_addr.size(); i++) chk("t2_addr", wr_addr[i], 10'(i));

    // 3: empty command goes straight to the kernel kick.
    clear_log();
    do_cmd(0, 0, 1, 0, 0, s);
    chk("t3_result", bus.result, 32'd0);
    chk("t3_writes", 64'(wr_addr.size()), 64'd0);
    chk("t3_kstart", 64'(kst), 64'd1);

    // 4: cmd_start pulses while busy are ignored.
    clear_log();
    do_cmd(4, 2, 0, 3, 1, s);
    chk("t4_kstart", 64'(kst), 64'd1);
    chk("t4_done", 64'(dn), 64'd1);

    // 5: kernel owns the port in RUN, nobody does in IDLE.
    bus.cmd_start = 1; bus.cmd_n = 10'd0;
    step();
    bus.cmd_start = 0;
    step();
    bus.k_write_en = 1; bus.k_write_addr = 10'd5; bus.k_write_val = 32'd7;
    bus.k_read_en = 1; bus.k_read_addr = 10'd9;
    #1;
    chk("t5_we", bus.mem_write_en, 1'b1);
    chk("t5_wa", bus.mem_write_addr, 10'd5);
    chk("t5_wv", bus.mem_write_val, 32'd7);
    chk("t5_ra", bus.mem_read_addr, 10'd9);
    bus.k_finish = 1; bus.k_res = 32'h55;
    step();
    bus.k_finish = 0;
    chk("t5_idle_we", bus.mem_write_en, 1'b0);
    chk("t5_idle_re", bus.mem_read_en, 1'b0);
    chk("t5_result", bus.result, 32'h55);
    bus.k_write_en = 0; bus.k_read_en = 0;

    // 6: reset after two of four words, then a clean three-word job.
    bus.cmd_start = 1; bus.cmd_n = 10'd4;
    step();
    bus.cmd_start = 0; bus.load_valid = 1; bus.load_data = 32'hA;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("t6_async_busy", bus.busy, 1'b0);
    chk("t6_async_ready", bus.load_ready, 1'b0);
    chk("t6_async_we", bus.mem_write_en, 1'b0);
    bus.load_valid = 0;
    step();
    rst_n = 1'b1;
    step();
    clear_log();
    do_cmd(3, 0, 1, 0, 0, s);
    chk("t6_result", bus.result, 32'd6);
    chk("t6_first_addr", (wr_addr.size() > 0) ? wr_addr[0] : 10'h3FF, 10'd0);
    chk("t6_writes", 64'(wr_addr.size()), 64'd3);

    // Randomized jobs with kernel-port noise and ignored inputs.
    knoise = 1;
    for (int j = 0; j < 40; j++) begin
      do_cmd(int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 0,
             int'($urandom_range(0, 3)), 1, s);
      repeat ($urandom_range(0, 2)) step();
    end
    knoise = 0;
    bus.k_write_en = 0; bus.k_read_en = 0;

    // Full-range count fills 0..1022 without wrapping.
    clear_log();
    do_cmd(1023, 0, 0, 0, 0, s);
    chk("max_writes", 64'(wr_addr.size()), 64'd1023);
    chk("max_last_addr", (wr_addr.size() > 0) ? wr_addr[$] : 10'h0, 10'd1022);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
